// File: rtl/codec_eval_pkg.sv
// Shared definitions for the codec evaluation sequencer.
//   DATA_W    - width of the uncoded data word
//   CODE_W    - width of the coded word (and of the bit-flip mask)
//   LFSR_TAPS - feedback taps of the right-shifting Fibonacci LFSR
//               (x^16+x^14+x^13+x^11+1 maps to state bits 0,2,3,5)
//   state_e   - sequencer FSM states
//   flip_mode_e - error injection modes
package codec_eval_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CODE_W = 21;

  localparam logic [DATA_W-1:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FlipNone   = 2'd0,
    FlipSingle = 2'd1,
    FlipDouble = 2'd2,
    FlipRsvd   = 2'd3
  } flip_mode_e;

endpackage

// File: rtl/codec_eval_lfsr.sv
// 16-bit Fibonacci LFSR used as the data-pattern source.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset (state returns to SEED)
//   load    - reload SEED (wins over advance)
//   advance - step the LFSR by one position
//   state   - current LFSR state
module codec_eval_lfsr
  import codec_eval_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] state
);

  logic [DATA_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SEED;
    end else if (advance) begin
      // Shift right; the new MSB is the parity of the tapped bits.
      state_d = {^(state_q & LFSR_TAPS), state_q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/codec_eval_seq.sv
// Codec evaluation sequencer: streams LFSR data words with optional injected
// bit flips into an external coder/decoder and counts mismatching decodes.
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   start           - run request, accepted only when idle
//   num_vectors     - vectors per run, sampled with start
//   flip_mode       - 0 none, 1 walking single, 2 adjacent double, 3 as 0
//   busy, done      - run in progress / one-cycle end-of-run pulse
//   codec_data_in   - data word to the coder (zero outside RUN)
//   codec_bit_flip  - error mask XORed onto the coded word (zero outside RUN)
//   codec_data_out  - decoded word, CODEC_LATENCY cycles after codec_data_in
//   vec_count       - vectors compared this run
//   err_count       - vectors whose decoded word mismatched
// Optional (macro CODEC_EVAL_FIRST_ERR_EN):
//   first_err_idx   - vector index of the first mismatch of the run
//   first_err_flip  - flip mask applied to that vector
module codec_eval_seq
  import codec_eval_pkg::*;
#(
  parameter int unsigned CODEC_LATENCY = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       num_vectors,
  input  logic [1:0]        flip_mode,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] codec_data_in,
  output logic [CODE_W-1:0] codec_bit_flip,
  input  logic [DATA_W-1:0] codec_data_out,
  output logic [15:0]       vec_count,
  output logic [15:0]       err_count
`ifdef CODEC_EVAL_FIRST_ERR_EN
  ,
  output logic [15:0]       first_err_idx,
  output logic [CODE_W-1:0] first_err_flip
`endif
);

  localparam logic [4:0] PtrMax    = 5'(CODE_W - 1);
  localparam logic [3:0] DrainLoad = 4'(CODEC_LATENCY - 1);

  state_e            state_q, state_d;
  flip_mode_e        mode_q, mode_d;
  logic              zero_q, zero_d;    // zero-length run accepted, DONE on next edge
  logic [15:0]       rem_q, rem_d;      // vectors still to issue
  logic [3:0]        drain_q, drain_d;
  logic [4:0]        ptr_q, ptr_d, ptr_inc;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       vec_q, vec_d;
  logic [15:0]       err_q, err_d;
  logic              accept, run, lfsr_load, lfsr_adv, mismatch;
  logic [DATA_W-1:0] lfsr_state;
  logic [CODE_W-1:0] flip_mask;

  logic [CODEC_LATENCY-1:0] dl_valid_q, dl_valid_d;
  logic [DATA_W-1:0]        dl_data_q [CODEC_LATENCY];

  codec_eval_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

  assign run     = (state_q == StRun);
  assign accept  = (state_q == StIdle) && start && !zero_q;
  assign ptr_inc = (ptr_q == PtrMax) ? 5'd0 : ptr_q + 5'd1;

  always_comb begin
    flip_mask = '0;
    unique case (mode_q)
      FlipSingle: flip_mask[ptr_q] = 1'b1;
      FlipDouble: begin
        flip_mask[ptr_q]   = 1'b1;
        flip_mask[ptr_inc] = 1'b1;
      end
      default: ;
    endcase
  end

  assign codec_data_in  = run ? lfsr_state : '0;
  assign codec_bit_flip = run ? flip_mask  : '0;

  // Sequencer FSM next state.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    zero_d    = zero_q;
    rem_d     = rem_q;
    drain_d   = drain_q;
    ptr_d     = ptr_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (zero_q) begin
          zero_d  = 1'b0;
          state_d = StDone;
        end else if (accept) begin
          lfsr_load = 1'b1;
          ptr_d     = '0;
          mode_d    = flip_mode_e'(flip_mode);
          rem_d     = num_vectors;
          if (num_vectors == 16'd0) begin
            zero_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        lfsr_adv = 1'b1;
        ptr_d    = ptr_inc;
        rem_d    = rem_q - 16'd1;
        if (rem_q == 16'd1) begin
          state_d = StDrain;
          drain_d = DrainLoad;
        end
      end
      StDrain: begin
        if (drain_q == 4'd0) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // busy/done lag the state by one edge so that done lands exactly one cycle
  // after DONE is entered and busy drops on that same cycle.
  assign busy_d = (state_q == StRun) || (state_q == StDrain) || zero_q;
  assign done_d = (state_q == StDone);

  always_comb begin
    dl_valid_d[0] = run;
    for (int i = 1; i < CODEC_LATENCY; i++) begin
      dl_valid_d[i] = dl_valid_q[i-1];
    end
  end

  assign mismatch = codec_data_out != dl_data_q[CODEC_LATENCY-1];

  always_comb begin
    vec_d = vec_q;
    err_d = err_q;
    if (accept) begin
      vec_d = '0;
      err_d = '0;
    end else if (dl_valid_q[CODEC_LATENCY-1]) begin
      vec_d = vec_q + 16'd1;
      if (mismatch) begin
        err_d = err_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mode_q     <= FlipNone;
      zero_q     <= 1'b0;
      rem_q      <= '0;
      drain_q    <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vec_q      <= '0;
      err_q      <= '0;
      dl_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      zero_q     <= zero_d;
      rem_q      <= rem_d;
      drain_q    <= drain_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      vec_q      <= vec_d;
      err_q      <= err_d;
      dl_valid_q <= dl_valid_d;
    end
  end

  // Expected-word storage needs no reset: it is only read under a valid.
  always_ff @(posedge clk) begin
    dl_data_q[0] <= codec_data_in;
    for (int i = 1; i < CODEC_LATENCY; i++) begin
      dl_data_q[i] <= dl_data_q[i-1];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign vec_count = vec_q;
  assign err_count = err_q;

`ifdef CODEC_EVAL_FIRST_ERR_EN
  logic [CODE_W-1:0] dl_flip_q [CODEC_LATENCY];
  logic [15:0]       fidx_q, fidx_d;
  logic [CODE_W-1:0] fflip_q, fflip_d;

  always_ff @(posedge clk) begin
    dl_flip_q[0] <= codec_bit_flip;
    for (int i = 1; i < CODEC_LATENCY; i++) begin
      dl_flip_q[i] <= dl_flip_q[i-1];
    end
  end

  // err_q == 0 marks that no mismatch has been captured yet this run.
  always_comb begin
    fidx_d  = fidx_q;
    fflip_d = fflip_q;
    if (accept) begin
      fidx_d  = '0;
      fflip_d = '0;
    end else if (dl_valid_q[CODEC_LATENCY-1] && mismatch && (err_q == 16'd0)) begin
      fidx_d  = vec_q;
      fflip_d = dl_flip_q[CODEC_LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fidx_q  <= '0;
      fflip_q <= '0;
    end else begin
      fidx_q  <= fidx_d;
      fflip_q <= fflip_d;
    end
  end

  assign first_err_idx  = fidx_q;
  assign first_err_flip = fflip_q;
`endif

endmodule

// File: doc/codec_eval_seq.md
CODEC_EVAL_SEQ -- requirements
Module: codec_eval_seq

Interface
REQ-001 Parameter CODEC_LATENCY, default 2: clock cycles from codec_data_in/codec_bit_flip to the matching codec_data_out; legal range 1..8.
REQ-002 Parameter LFSR_SEED, default 16'hACE1: nonzero seed for the 16-bit data-pattern LFSR.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  run request, sampled in IDLE only.
REQ-006 num_vectors  input  16  vectors per run, sampled with start.
REQ-007 flip_mode  input  2  injection mode, sampled with start: 0 none, 1 single walking, 2 adjacent double, 3 reserved (treated as 0).
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 done  output  1  one-cycle end-of-run pulse.
REQ-010 codec_data_in  output  16  data word to the coder.
REQ-011 codec_bit_flip  output  21  error mask XORed onto the coded word.
REQ-012 codec_data_out  input  16  decoded word from the decoder.
REQ-013 vec_count  output  16  vectors compared this run.
REQ-014 err_count  output  16  vectors whose decoded word mismatched.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN, DONE; IDLE->RUN on start with num_vectors!=0; IDLE->DONE on start with num_vectors==0; RUN->DRAIN after the last vector is issued; DRAIN->DONE after CODEC_LATENCY cycles; DONE->IDLE unconditionally.
REQ-016 Accepting start clears vec_count, err_count, walk pointer p, and reloads the LFSR with LFSR_SEED; start outside IDLE is ignored.
REQ-017 In RUN, one vector per cycle: codec_data_in = LFSR state, then LFSR advances (x^16+x^14+x^13+x^11+1, Fibonacci).
REQ-018 Mode 1: codec_bit_flip = one-hot at p; mode 2: bits p and (p+1) mod 21 (p=20 -> bits 20 and 0); p increments per vector, wrapping 20->0; mode 0/3: all zeros.
REQ-019 Outside RUN, codec_data_in and codec_bit_flip are driven to zero.
REQ-020 Expected words travel through a CODEC_LATENCY-deep valid+data delay line; on each emerging valid, vec_count increments and err_count increments if codec_data_out != expected.
REQ-021 err_count <= vec_count at all times; both hold after done until the next accepted start.
REQ-022 done asserts exactly num_vectors + CODEC_LATENCY + 1 cycles after the start-accepting edge (2 cycles for num_vectors==0); busy deasserts in the same cycle done asserts.
REQ-023 Data bubbles are not permitted; issue is continuous through RUN.

Reset
REQ-024 rst_n low forces IDLE, busy=0, done=0, codec_data_in=0, codec_bit_flip=0, vec_count=0, err_count=0, p=0, delay-line valids=0, LFSR=LFSR_SEED.
REQ-025 Reset mid-run aborts without a done pulse; operation resumes from IDLE after release.

Configuration
REQ-026 Macro CODEC_EVAL_FIRST_ERR_EN defined: adds outputs first_err_idx[15:0] and first_err_flip[20:0] capturing the vec_count index and bit_flip mask of the first mismatch of a run (0 when none; cleared on start); the flip mask travels in the delay line alongside the data.
REQ-027 Macro undefined: those ports and the extra delay-line storage are absent; all other behaviour is identical.

Structure
REQ-028 Package codec_eval_pkg holds DATA_W=16, CODE_W=21, the FSM state enum, the flip_mode enum and the LFSR taps constant.
REQ-029 Sub-module codec_eval_lfsr (load, advance, 16-bit state) is instantiated once; everything else stays in codec_eval_seq.

Verification
REQ-030 Mode 0, num_vectors=100, Hamming codec: done at cycle 100+2+1, vec_count=100, err_count=0.
REQ-031 Mode 1, num_vectors=42: codec_bit_flip walks bit 0..20 twice; err_count=0 with the single-error-correcting codec.
REQ-032 Mode 2, num_vectors=21: bit_flip at p=20 equals 21'h100001; err_count equals the bench reference-model count.
REQ-033 num_vectors=0: done two cycles after start, both counts 0, codec outputs stay 0.
REQ-034 Bench codec stub inverting bit 0, num_vectors=10: err_count=10; with CODEC_EVAL_FIRST_ERR_EN, first_err_idx=0.
REQ-035 rst_n pulsed low at vector 5 of 50: no done, all outputs at reset values, new start yields a clean 50-vector run.
